memoria_arbitro: RTL
====================

// Module: memoria_arbitro
// PURPOSE
//  Two-requester controller for the single-port 256-word data memory (Wen/Ren/Adress/DataW/DataR).
//  Port 0 = instruction fetch (read-only); port 1 = load/store unit (read or write).
//  Round-robin arbitration, latching of the winning request, and driving of the memory strobes.
//  Returns read data/ack to the winner. Never asserts Wen and Ren together.
// PARAMETERS
//  DATA_W   32   data word width (port data and memory DataW/DataR)
//  ADDR_W   32   address width (ports and memory Adress)
//  DEPTH    256  valid word locations; addr >= DEPTH is out of range
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  req0         in   1       port 0 read request; hold until ack0
//  addr0        in   ADDR_W  port 0 word address
//  ack0         out  1       1-cycle completion pulse, port 0
//  req1         in   1       port 1 request; hold until ack1
//  wen1         in   1       port 1: 1 = write, 0 = read
//  addr1        in   ADDR_W  port 1 word address
//  wdata1       in   DATA_W  port 1 write data
//  ack1         out  1       1-cycle completion pulse, port 1
//  rdata        out  DATA_W  read data, valid while ack0 or ack1 is high (read ops)
//  err          out  1       pulses with ack when the latched addr >= DEPTH
//  mem_wen      out  1       to memory Wen
//  mem_ren      out  1       to memory Ren
//  mem_addr     out  ADDR_W  to memory Adress
//  mem_dataw    out  DATA_W  to memory DataW
//  mem_datar    in   DATA_W  from memory DataR (combinational read)
// BEHAVIOUR
//  - Reset (async): state=IDLE, last_grant=1, every output and latch = 0. The memory strobes drop
//    immediately. An in-flight access is abandoned and no ack is issued.
//  - FSM: IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
//  - IDLE: if req0|req1 is high, arbitrate and latch port id, op, addr and wdata, then go to ACCESS.
//    Otherwise stay in IDLE.
//  - Arbitration: if only one port requests, it wins. If both request, the port != last_grant wins.
//    last_grant updates on every grant.
//  - ACCESS (exactly 1 cycle):
//      - In-range addr: mem_addr = latched addr; mem_wen = op; mem_ren = !op; mem_dataw = wdata
//        for a write, 0 for a read.
//      - Out of range: all mem_* = 0.
//      - At the clock edge, rdata <= mem_datar for an in-range read, else 0.
//  - RESP (exactly 1 cycle): ack of the latched port = 1; err = 1 if out of range; all mem_* = 0.
//      - Only the other port's req is sampled in this cycle. If it is high, grant it and go straight
//        to ACCESS; otherwise go to IDLE.
//      - The acked port's req is ignored in this cycle, so a held req is re-arbitrated from IDLE.
//  - Latency: req seen in IDLE at cycle N -> ack at N+2.
//    Two ports alternating -> one access per 2 cycles.
//  - Request fields are captured only at grant. A req deasserted after grant does not cancel the
//    access; the ack still pulses.
//  - wen1 is ignored while port 1 is not being granted. Port 0 is never a write.
//  - Outside ACCESS, mem_wen, mem_ren, mem_addr and mem_dataw = 0. mem_wen & mem_ren is never 1.
//  - rdata holds its value until the next captured read or error. rdata = 0 after any write.
//  - All outputs are registered or decoded from the state register. There is no combinational
//    path from req* to ack*/mem_*.
// STRUCTURE
//  - Shared package (memoria_pkg): state encoding (IDLE/ACCESS/RESP), port ids P_FETCH=0 and
//    P_LS=1, MEM_DEPTH=256, op codes OP_RD=0 and OP_WR=1.
//  - Sub-module arbitro_rr2: combinational 2-way round-robin grant.
//      - Inputs: req[1:0], last_grant, mask.
//      - Output: grant_id plus a valid flag.
//      - mask excludes the acked port during RESP.
//  - Top: FSM, request latches, last_grant register, memory drive, rdata/err registers.
// TESTING
//  1. Reset with req0=1 held -> after release ack0 on 3rd edge, mem_ren=1 and mem_addr=addr0 in
//     ACCESS, rdata=mem_datar.
//  2. Port 1 write: wen1=1, addr1=10, wdata1=0xDEADBEEF -> mem_wen=1, mem_ren=0, mem_dataw=0xDEADBEEF
//     for 1 cycle, then ack1.
//     Follow with a port 1 read of addr 10 -> rdata=0xDEADBEEF.
//  3. req0 and req1 high together, held -> grants alternate 0,1,0,1. One ack every 2 cycles.
//     mem_wen&mem_ren never 1.
//  4. Port 1 read addr1=256 -> no mem strobe, ack1 and err=1 together, rdata=0.
//     addr1=255 -> normal access, err=0.
//  5. rst asserted mid-ACCESS -> mem_* = 0 immediately, no ack, state IDLE.
//     After release, the held req0 is re-granted.
//  6. req1 dropped the cycle after its grant -> access still performed, ack1 pulses once.

Source files
------------

// File: rtl/memoria_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : memoria_pkg                                                 |
// | Purpose  : Shared types and constants for the data-memory arbiter:     |
// |            FSM state encoding, requester ids, op codes, memory depth.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package memoria_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Requester ids
   localparam logic P_FETCH = 1'b0;
   localparam logic P_LS    = 1'b1;

   // Operation codes
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam int MEM_DEPTH = 256;

endpackage : memoria_pkg
`default_nettype wire

// File: rtl/arbitro_rr2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : arbitro_rr2                                                 |
// | Purpose  : Combinational two-way round-robin grant.                    |
// | Ports    : req[1:0]    raw requests (bit 0 = fetch, bit 1 = load/store)|
// |            last_grant  id of the most recently granted port            |
// |            mask[1:0]   requests to ignore this cycle                   |
// |            grant_id    winning port id                                 |
// |            grant_valid at least one unmasked request present           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module arbitro_rr2
   import memoria_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] mask,
   output logic       grant_id,
   output logic       grant_valid
);

   logic [1:0] w_req;

   always_comb begin
      w_req       = req & ~mask;
      grant_valid = |w_req;
      grant_id    = P_FETCH;
      if (w_req == 2'b11) begin
         // Contention: the port that did not win last time goes next.
         grant_id = ~last_grant;
      end else if (w_req[1]) begin
         grant_id = P_LS;
      end
   end

endmodule : arbitro_rr2
`default_nettype wire

// File: rtl/memoria_arbitro.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : memoria_arbitro                                             |
// | Purpose  : Two-requester controller for the single-port data memory.   |
// |            Port 0 = instruction fetch (read only), port 1 = load/store.|
// |            Round-robin arbitration, request latching, memory strobes,  |
// |            read data / ack / err return to the winning port.           |
// | Ports    : clk, rst (async, active-high)                               |
// |            req0/addr0/ack0                 fetch port                  |
// |            req1/wen1/addr1/wdata1/ack1     load/store port             |
// |            rdata, err                      shared response             |
// |            mem_wen/mem_ren/mem_addr/mem_dataw/mem_datar  memory side   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module memoria_arbitro
   import memoria_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = MEM_DEPTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   input  logic              req1,
   input  logic              wen1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dataw,
   input  logic [DATA_W-1:0] mem_datar
);

   state_t              r_state;
   state_t              w_state_next;
   logic                r_port;
   logic                r_op;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;

   logic [1:0]          w_mask;
   logic                w_grant_id;
   logic                w_grant_valid;
   logic                w_take;
   logic                w_in_range;

   assign w_in_range = (r_addr < ADDR_W'(DEPTH));

   arbitro_rr2 u_arb (
      .req         ({req1, req0}),
      .last_grant  (r_last_grant),
      .mask        (w_mask),
      .grant_id    (w_grant_id),
      .grant_valid (w_grant_valid)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, grant control and state-decoded outputs
   always_comb begin
      w_state_next = r_state;
      w_mask       = 2'b11;
      w_take       = 1'b0;
      ack0         = 1'b0;
      ack1         = 1'b0;
      err          = 1'b0;
      mem_wen      = 1'b0;
      mem_ren      = 1'b0;
      mem_addr     = '0;
      mem_dataw    = '0;

      case (r_state)
         ST_IDLE: begin
            w_mask = 2'b00;
            if (w_grant_valid) begin
               w_take       = 1'b1;
               w_state_next = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Out-of-range accesses never touch the memory.
            if (w_in_range) begin
               mem_wen   = (r_op == OP_WR);
               mem_ren   = (r_op == OP_RD);
               mem_addr  = r_addr;
               mem_dataw = r_wdata;
            end
            w_state_next = ST_RESP;
         end

         ST_RESP: begin
            ack0 = (r_port == P_FETCH);
            ack1 = (r_port == P_LS);
            err  = ~w_in_range;
            // The port being acked is masked so its still-held request
            // cannot be granted back-to-back; only the other port may chain.
            w_mask = (r_port == P_LS) ? 2'b10 : 2'b01;
            if (w_grant_valid) begin
               w_take       = 1'b1;
               w_state_next = ST_ACCESS;
            end else begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Request latches, round-robin history and read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_port       <= P_FETCH;
         r_op         <= OP_RD;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_last_grant <= 1'b1;
         r_rdata      <= '0;
      end else begin
         if (w_take) begin
            r_port       <= w_grant_id;
            r_last_grant <= w_grant_id;
            if (w_grant_id == P_LS) begin
               r_op    <= wen1;
               r_addr  <= addr1;
               // Keeping write data zero for reads lets mem_dataw come
               // straight from the latch.
               r_wdata <= wen1 ? wdata1 : '0;
            end else begin
               r_op    <= OP_RD;
               r_addr  <= addr0;
               r_wdata <= '0;
            end
         end

         if (r_state == ST_ACCESS) begin
            r_rdata <= (w_in_range && (r_op == OP_RD)) ? mem_datar : '0;
         end
      end
   end

   assign rdata = r_rdata;

endmodule : memoria_arbitro
`default_nettype wire
